// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the two-phase 16-bit SRAM controller.
package sram_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;
  localparam int CNT_W  = 4;
  localparam int HALF_W = 16;
endpackage

// File: rtl/sram_wait_cnt.sv
// Loadable down-counter timing one half-word phase; phase_last marks its final cycle.
module sram_wait_cnt
  import sram_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] cnt,
  output logic             phase_last
);
  always_ff @(posedge clk or posedge rst)
    if (rst)             cnt <= '0;
    else if (load)       cnt <= load_val;
    else if (cnt != '0)  cnt <= cnt - CNT_W'(1);

  assign phase_last = (cnt == '0);
endmodule

// File: rtl/sram_ctrl.sv
// MEM-stage word access served from a 16-bit async SRAM in two half-word phases.
// Optional one-entry last-read buffer enabled by SRAM_LAST_READ_BUF_EN.
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int SRAM_ADDR_W = 18,
  parameter int WAIT_CYCLES = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   MEM_R_EN,
  input  logic                   MEM_W_EN,
  input  logic [31:0]            Address,
  input  logic [31:0]            ST_val,
  output logic [31:0]            Mem_read_value,
  output logic                   ready,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic [HALF_W-1:0]      sram_dq_out,
  input  logic [HALF_W-1:0]      sram_dq_in,
  output logic                   sram_dq_oe,
  output logic                   sram_we_n
);
  state_t           state;
  logic             is_wr;
  logic [31:0]      wdata;
  logic [HALF_W-1:0] rd_lo;
  logic [31:0]      rd_q;
  logic [CNT_W-1:0] cnt;
  logic             phase_last;
  logic             req, buf_hit, start, load;
  logic [31:0]      hit_data;
  logic             unused_addr;

  assign req   = MEM_R_EN | MEM_W_EN;
  assign start = (state == IDLE) && req && !buf_hit;
  assign load  = start || (state == LO && phase_last);
  assign ready = (state == IDLE && !req) || (state == DONE) || buf_hit;
  assign unused_addr = ^{Address[31:SRAM_ADDR_W+1], Address[1:0]};

  sram_wait_cnt u_cnt (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .load_val   (CNT_W'(WAIT_CYCLES)),
    .cnt        (cnt),
    .phase_last (phase_last)
  );

  // Strobe stays low until the final cycle of a phase, which holds address/data.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state       <= IDLE;
      is_wr       <= 1'b0;
      wdata       <= '0;
      rd_lo       <= '0;
      rd_q        <= '0;
      sram_addr   <= '0;
      sram_dq_out <= '0;
      sram_dq_oe  <= 1'b0;
      sram_we_n   <= 1'b1;
    end else begin
      case (state)
        IDLE:
          if (start) begin
            state       <= LO;
            is_wr       <= MEM_W_EN;
            wdata       <= ST_val;
            sram_addr   <= {Address[SRAM_ADDR_W:2], 1'b0};
            sram_dq_out <= ST_val[HALF_W-1:0];
            sram_dq_oe  <= MEM_W_EN;
            sram_we_n   <= ~MEM_W_EN;
          end else if (buf_hit) begin
            rd_q <= hit_data;
          end
        LO:
          if (phase_last) begin
            state        <= HI;
            sram_addr[0] <= 1'b1;
            sram_dq_out  <= wdata[31:16];
            sram_we_n    <= ~is_wr;
            rd_lo        <= sram_dq_in;
          end else begin
            sram_we_n <= ~is_wr | (cnt == CNT_W'(1));
          end
        HI:
          if (phase_last) begin
            state      <= DONE;
            sram_dq_oe <= 1'b0;
            sram_we_n  <= 1'b1;
            if (!is_wr) rd_q <= {sram_dq_in, rd_lo};
          end else begin
            sram_we_n <= ~is_wr | (cnt == CNT_W'(1));
          end
        default: state <= IDLE;
      endcase
    end

`ifdef SRAM_LAST_READ_BUF_EN
  logic                   buf_valid;
  logic [SRAM_ADDR_W-2:0] buf_addr;
  logic [31:0]            buf_data;
  logic                   fin;

  assign fin      = (state == HI) && phase_last;
  assign buf_hit  = (state == IDLE) && MEM_R_EN && !MEM_W_EN && buf_valid &&
                    (buf_addr == Address[SRAM_ADDR_W:2]);
  assign hit_data = buf_data;
  assign Mem_read_value = buf_hit ? buf_data : rd_q;

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      buf_valid <= 1'b0;
      buf_addr  <= '0;
      buf_data  <= '0;
    end else if (fin && !is_wr) begin
      buf_valid <= 1'b1;
      buf_addr  <= sram_addr[SRAM_ADDR_W-1:1];
      buf_data  <= {sram_dq_in, rd_lo};
    end else if (fin && buf_valid && buf_addr == sram_addr[SRAM_ADDR_W-1:1]) begin
      buf_data <= wdata;
    end
`else
  logic unused_wlo;
  assign unused_wlo     = ^wdata[HALF_W-1:0];
  assign buf_hit        = 1'b0;
  assign hit_data       = '0;
  assign Mem_read_value = rd_q;
`endif
endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: a WAIT_CYCLES=3 instance and a WAIT_CYCLES=0 instance, each on an SRAM model.
module tb_sram_ctrl;
  localparam int W3 = 3;
`ifdef SRAM_LAST_READ_BUF_EN
  localparam bit BUF = 1'b1;
`else
  localparam bit BUF = 1'b0;
`endif

  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

  logic        r3 = 0, w3 = 0, r0 = 0, w0 = 0;
  logic [31:0] a3 = 0, s3 = 0, a0 = 0, s0 = 0;
  logic [31:0] rv3, rv0;
  logic        rdy3, rdy0, oe3, oe0, we3, we0;
  logic [17:0] sa3, sa0;
  logic [15:0] dqo3, dqo0, dqi3, dqi0;

  sram_ctrl #(.SRAM_ADDR_W(18), .WAIT_CYCLES(W3)) dut (
    .clk(clk), .rst(rst), .MEM_R_EN(r3), .MEM_W_EN(w3), .Address(a3), .ST_val(s3),
    .Mem_read_value(rv3), .ready(rdy3), .sram_addr(sa3), .sram_dq_out(dqo3),
    .sram_dq_in(dqi3), .sram_dq_oe(oe3), .sram_we_n(we3));

  sram_ctrl #(.SRAM_ADDR_W(18), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .MEM_R_EN(r0), .MEM_W_EN(w0), .Address(a0), .ST_val(s0),
    .Mem_read_value(rv0), .ready(rdy0), .sram_addr(sa0), .sram_dq_out(dqo0),
    .sram_dq_in(dqi0), .sram_dq_oe(oe0), .sram_we_n(we0));

  // Asynchronous SRAM models: read is combinational, write lands while we_n is low.
  logic [15:0] sram3 [256];
  logic [15:0] sram0 [256];
  assign dqi3 = sram3[sa3[7:0]];
  assign dqi0 = sram0[sa0[7:0]];
  always @(posedge clk) begin
    if (!we3 && oe3) sram3[sa3[7:0]] <= dqo3;
    if (!we0 && oe0) sram0[sa0[7:0]] <= dqo0;
  end

  // Word-level reference: memory contents, last read result, buffered word.
  logic [31:0] ref_mem [2][128];
  logic [31:0] last_rd [2];
  bit          bv [2];
  logic [6:0]  bw [2];

  int vec = 0, err = 0;
  int last_lat;
  logic [31:0] last_rv;
  logic [17:0] l_addr [64];
  logic [15:0] l_dq [64];
  logic        l_oe [64];
  logic        l_we [64];

  task automatic do_txn(input bit sel, input bit r, input bit w, input logic [31:0] a,
                        input logic [31:0] v, input bit idle_after);
    int wc, lat, exp_lat;
    bit hit, bad;
    logic [6:0] wd;
    logic [31:0] exp_rv;
    wc = sel ? 0 : W3;
    wd = a[8:2];
    hit = BUF && r && !w && bv[sel] && (bw[sel] == wd);
    exp_lat = hit ? 0 : 2 * wc + 3;
    exp_rv = (r && !w) ? ref_mem[sel][wd] : last_rd[sel];
    if (sel) begin r0 = r; w0 = w; a0 = a; s0 = v; end
    else     begin r3 = r; w3 = w; a3 = a; s3 = v; end
    lat = -1;
    for (int c = 0; c < 64; c++) begin
      #1;
      l_addr[c] = sel ? sa0 : sa3;
      l_dq[c]   = sel ? dqo0 : dqo3;
      l_oe[c]   = sel ? oe0 : oe3;
      l_we[c]   = sel ? we0 : we3;
      if ((sel ? rdy0 : rdy3) === 1'b1) begin
        lat = c;
        last_rv = sel ? rv0 : rv3;
        break;
      end
      @(negedge clk);
    end
    last_lat = lat;
    vec++;
    if (lat != exp_lat) begin
      err++;
      $display("FAIL latency dut%0d addr=%h: got %0d, expected %0d", sel, a, lat, exp_lat);
    end else begin
      bad = (l_oe[0] !== 1'b0) || (l_we[0] !== 1'b1);
      if (!hit)
        for (int c = 1; c <= 2 * wc + 2; c++) begin
          int ph, pos;
          ph  = (c - 1) / (wc + 1);
          pos = (c - 1) % (wc + 1);
          if (l_addr[c] !== {a[18:2], ph[0]}) bad = 1;
          if (l_oe[c] !== w) bad = 1;
          if (l_we[c] !== (w ? (wc != 0 && pos == wc) : 1'b1)) bad = 1;
          if (w && l_dq[c] !== (ph != 0 ? v[31:16] : v[15:0])) bad = 1;
        end
      vec++;
      if (bad) begin
        err++;
        $display("FAIL bus_seq dut%0d addr=%h r=%0d w=%0d: c1 addr=%h dq=%h we=%b, expected addr=%h",
                 sel, a, r, w, l_addr[1], l_dq[1], l_we[1], {a[18:2], 1'b0});
      end
      vec++;
      if (last_rv !== exp_rv) begin
        err++;
        $display("FAIL read_value dut%0d addr=%h: got %h, expected %h", sel, a, last_rv, exp_rv);
      end
    end
    if (w) ref_mem[sel][wd] = v;
    else if (r) begin last_rd[sel] = ref_mem[sel][wd]; bv[sel] = 1; bw[sel] = wd; end
    @(negedge clk);
    if (idle_after) begin
      if (sel) begin r0 = 0; w0 = 0; end else begin r3 = 0; w3 = 0; end
      #1;
      vec++;
      if ((sel ? rv0 : rv3) !== last_rd[sel]) begin
        err++;
        $display("FAIL hold dut%0d: got %h, expected %h", sel, sel ? rv0 : rv3, last_rd[sel]);
      end
    end
  endtask

  task automatic test_reset;
    @(negedge clk); #1;
    vec++;
    if (rdy3 !== 1'b1 || rdy0 !== 1'b1) begin
      err++; $display("FAIL reset_ready: got %b/%b, expected 1/1", rdy3, rdy0);
    end
    vec++;
    if (rv3 !== 32'h0 || sa3 !== 18'h0 || dqo3 !== 16'h0) begin
      err++; $display("FAIL reset_data: rv=%h addr=%h dq=%h, expected zeros", rv3, sa3, dqo3);
    end
    vec++;
    if (oe3 !== 1'b0 || we3 !== 1'b1 || oe0 !== 1'b0 || we0 !== 1'b1) begin
      err++; $display("FAIL reset_strobes: oe=%b we_n=%b, expected 0/1", oe3, we3);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write;
    do_txn(0, 0, 1, 32'h10, 32'hDEADBEEF, 1);
    vec++;
    if (l_addr[1] !== 18'h8 || l_dq[1] !== 16'hBEEF || l_addr[5] !== 18'h9 ||
        l_dq[5] !== 16'hDEAD || l_we[3] !== 1'b0 || l_we[4] !== 1'b1 || l_we[8] !== 1'b1) begin
      err++;
      $display("FAIL write_directed: a1=%h d1=%h a5=%h d5=%h we3=%b we4=%b, expected 8 BEEF 9 DEAD 0 1",
               l_addr[1], l_dq[1], l_addr[5], l_dq[5], l_we[3], l_we[4]);
    end
  endtask

  task automatic test_read;
    do_txn(0, 1, 0, 32'h10, 32'h0, 1);
    vec++;
    if (last_lat != 9 || last_rv !== 32'hDEADBEEF) begin
      err++; $display("FAIL read_directed: lat=%0d val=%h, expected 9 DEADBEEF", last_lat, last_rv);
    end
  endtask

  task automatic test_read_write_both;
    do_txn(0, 1, 1, 32'h20, 32'h12345678, 1);
    vec++;
    if (l_dq[1] !== 16'h5678 || l_dq[5] !== 16'h1234 || last_rv !== 32'hDEADBEEF) begin
      err++; $display("FAIL both_as_write: dq=%h/%h rv=%h, expected 5678/1234 DEADBEEF",
                      l_dq[1], l_dq[5], last_rv);
    end
  endtask

  task automatic test_reset_mid;
    r3 = 0; w3 = 1; a3 = 32'h40; s3 = 32'hA5A55A5A;
    repeat (6) @(negedge clk);
    #1;
    vec++;
    if (we3 !== 1'b0 || oe3 !== 1'b1) begin
      err++; $display("FAIL pre_reset_phase: we_n=%b oe=%b, expected 0/1", we3, oe3);
    end
    rst = 1'b1;
    #1;
    vec++;
    if (we3 !== 1'b1 || oe3 !== 1'b0 || sa3 !== 18'h0 || rv3 !== 32'h0 || rdy3 !== 1'b0) begin
      err++; $display("FAIL async_reset: we_n=%b oe=%b addr=%h rv=%h rdy=%b, expected 1 0 0 0 0",
                      we3, oe3, sa3, rv3, rdy3);
    end
    last_rd[0] = '0; last_rd[1] = '0; bv[0] = 0; bv[1] = 0;
    @(negedge clk);
    rst = 1'b0;
    do_txn(0, 0, 1, 32'h40, 32'hA5A55A5A, 1);
  endtask

  task automatic test_random;
    for (int i = 0; i < 40; i++) begin
      int kind, word;
      logic [31:0] a;
      bit idle;
      kind = $urandom_range(0, 3);
      word = $urandom_range(0, 15);
      a = ($urandom() & 32'hFFF8_0000) | 32'(word << 2) | 32'($urandom_range(0, 3));
      idle = (i == 39) ? 1'b1 : 1'($urandom_range(0, 1));
      do_txn(0, kind != 2, kind >= 2, a, $urandom(), idle);
      if (idle) repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 4; i++)
      do_txn(1, 0, 1, 32'(32 + 4 * i), $urandom(), 1);
    for (int i = 0; i < 4; i++) begin
      do_txn(1, 1, 0, 32'(32 + 4 * i), 32'h0, i == 3);
      vec++;
      if (last_lat != 3) begin
        err++; $display("FAIL back_to_back_latency read%0d: got %0d, expected 3", i, last_lat);
      end
    end
  endtask

  task automatic test_read_buffer;
`ifdef SRAM_LAST_READ_BUF_EN
    logic [17:0] sa_before;
    do_txn(0, 1, 0, 32'h10, 32'h0, 1);
    sa_before = sa3;
    do_txn(0, 1, 0, 32'h10, 32'h0, 1);
    vec++;
    if (last_lat != 0 || sa3 !== sa_before || we3 !== 1'b1 || oe3 !== 1'b0) begin
      err++; $display("FAIL buffer_hit: lat=%0d addr=%h/%h we_n=%b, expected 0 unchanged 1",
                      last_lat, sa3, sa_before, we3);
    end
    do_txn(0, 0, 1, 32'h10, 32'hCAFEF00D, 1);
    do_txn(0, 1, 0, 32'h10, 32'h0, 1);
    vec++;
    if (last_lat != 0 || last_rv !== 32'hCAFEF00D) begin
      err++; $display("FAIL buffer_update: lat=%0d val=%h, expected 0 CAFEF00D", last_lat, last_rv);
    end
`endif
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin sram3[i] = '0; sram0[i] = '0; end
    for (int i = 0; i < 128; i++) begin ref_mem[0][i] = '0; ref_mem[1][i] = '0; end
    last_rd[0] = '0; last_rd[1] = '0; bv[0] = 0; bv[1] = 0; bw[0] = '0; bw[1] = '0;
    test_reset;
    test_write;
    test_read;
    test_read_write_both;
    test_reset_mid;
    test_random;
    test_back_to_back;
    test_read_buffer;
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
